alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Initiator side of the ALU control interface. Accepts decoded-instruction requests (ALUOp + funct + operands) over a valid/ready handshake.
- Translates each request into the 4-bit ALU control code, drives the ALU operand and control lines, captures Result/Zero, and returns them over a valid/ready response channel.
- Sits between the instruction decode stage and the combinational ALU in the multi-cycle datapath.
- Guarantees the ALU never receives an unsupported control code.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 16, width of the saturating operation and illegal-request counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_aluop  in  2  00 load/store add, 01 branch sub, 10 R-type (use funct), 11 reserved.
- req_funct  in  6  R-type function field.
- req_a, req_b  in  WIDTH  operands.
- alu_a, alu_b  out  WIDTH  operands driven to the ALU.
- alu_cntrl  out  4  ALU control code.
- alu_result  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_cntrl).
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  WIDTH  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_illegal  out  1  request was undecodable; result forced to 0.
- op_count  out  CNT_W  completed legal operations, saturating.
- illegal_count  out  CNT_W  illegal requests, saturating.

Behaviour:
- Control codes: AND=0000, OR=0001, ADD=0010, SUB=0100, SLT=1000. No other value is ever driven.
- Decode table:
  - aluop 00 -> ADD; aluop 01 -> SUB.
  - aluop 10: funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; any other funct is illegal.
  - aluop 11 is illegal.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: req_ready=1. On req_valid, register operands and the decoded code.
    - Legal request -> EXEC.
    - Illegal request -> RESP with rsp_result=0, rsp_zero=0, rsp_illegal=1. The ALU is not exercised.
  - EXEC: one cycle with alu_a/alu_b/alu_cntrl stable from registers. At the end of the cycle, capture alu_result/alu_zero into the rsp registers, set rsp_illegal=0, go to RESP.
  - RESP: rsp_valid=1 and rsp_* held stable. When rsp_ready=1, go to IDLE; op_count or illegal_count increments on that cycle.
- req_ready=1 only in IDLE. Backpressure in RESP stalls indefinitely with all outputs held.
- Latency, legal request: handshake at cycle N -> rsp_valid at cycle N+2. Illegal request: rsp_valid at N+1.
- Throughput: one request per 3 cycles (legal) or 2 cycles (illegal). No overlap. A req_valid held during EXEC/RESP is not consumed.
- In IDLE, alu_cntrl is ADD and alu_a/alu_b keep their last values. The ALU's Result/Zero in that state are don't-care.
- Counters saturate at all-ones and do not wrap.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_illegal=0, alu_a=0, alu_b=0, alu_cntrl=ADD (0010), both counters 0.
- Reset mid-operation (EXEC or RESP) discards the in-flight request with no response and no counter update.
- Reset has priority over every handshake in the same cycle.

Decomposition:
- Shared package holds the ALU control-code constants, the ALUOp encodings, the supported funct constants, and the FSM state enumeration. The ALU's case decode uses the same package.
- One natural sub-module, alu_ctrl_decode: purely combinational aluop/funct -> {cntrl, illegal}. It is reusable by the single-cycle datapath.

Test Plan:
- aluop=10, funct=100000, A=5, B=7, rsp_ready=1 -> alu_cntrl=0010 during EXEC; rsp_valid two cycles after accept with rsp_result=12, rsp_zero=0; op_count=1.
- aluop=01, A=B=0x0000_00FF -> cntrl 0100, rsp_result=0, rsp_zero=1.
- aluop=10, funct=101010, A=3, B=9 -> cntrl 1000, result 1.
  - Then A=9, B=3 -> result 0, zero=1.
- aluop=10, funct=100111 (NOR); then aluop=11 -> each gives rsp_valid one cycle after accept with rsp_illegal=1, result 0; alu_cntrl never leaves the legal set; illegal_count=2, op_count unchanged.
- AND 0xF0F0_F0F0 & 0x0FF0_0FF0 with rsp_ready low 5 cycles -> rsp_result=0x00F0_00F0 held stable; req_ready=0 throughout; second queued request accepted only after the response handshake.
- Assert rst during EXEC -> next cycle rsp_valid=0, req_ready=1, counters unchanged. Preload op_count to all-ones and complete one op -> stays all-ones.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU control path: ALU control codes, ALUOp
// encodings from the main decoder, supported R-type funct values and the
// sequencer FSM state encoding. The ALU's own case decode uses the same
// control-code constants, so the two sides cannot drift apart.
package alu_op_sequencer_pkg;

   // ALU control codes. Only these five values are ever driven to the ALU.
   typedef enum logic [3:0] {
      CNTRL_AND = 4'b0000,
      CNTRL_OR  = 4'b0001,
      CNTRL_ADD = 4'b0010,
      CNTRL_SUB = 4'b0100,
      CNTRL_SLT = 4'b1000
   } alu_cntrl_e;

   // ALUOp field produced by the main instruction decoder
   localparam logic [1:0] ALUOP_MEM    = 2'b00;  // load/store address add
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // branch compare subtract
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;  // operation taken from funct
   localparam logic [1:0] ALUOP_RSVD   = 2'b11;  // undefined

   // R-type funct values the ALU supports
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer_decode.sv
// alu_ctrl_decode: purely combinational ALUOp/funct -> ALU control decode.
// Shared with the single-cycle datapath.
//
// Ports:
//   aluop   in  2  ALUOp from the main decoder
//   funct   in  6  R-type function field
//   cntrl   out 4  ALU control code (always one of the five legal codes)
//   illegal out 1  request cannot be mapped to a supported operation
module alu_ctrl_decode
   import alu_op_sequencer_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [3:0] cntrl,
   output logic       illegal
);

   // Undecodable requests still report ADD so a legal code is always
   // presented, even if a caller ignores the illegal flag.
   always_comb begin
      cntrl   = CNTRL_ADD;
      illegal = 1'b0;
      case (aluop)
         ALUOP_MEM:    cntrl = CNTRL_ADD;
         ALUOP_BRANCH: cntrl = CNTRL_SUB;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD: cntrl = CNTRL_ADD;
               FUNCT_SUB: cntrl = CNTRL_SUB;
               FUNCT_AND: cntrl = CNTRL_AND;
               FUNCT_OR:  cntrl = CNTRL_OR;
               FUNCT_SLT: cntrl = CNTRL_SLT;
               default:   illegal = 1'b1;
            endcase
         end
         ALUOP_RSVD:   illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator side of the ALU control interface.
// Accepts one decoded request at a time, drives the external combinational
// ALU for one cycle, captures its Result/Zero and returns them on a
// valid/ready response channel. Undecodable requests bypass the ALU and
// respond immediately with the illegal flag set.
//
// Ports:
//   clk, rst                   clock (rising edge), synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_aluop, req_funct       instruction decode fields
//   req_a, req_b               operands
//   alu_a, alu_b, alu_cntrl    operands and control code driven to the ALU
//   alu_result, alu_zero       ALU outputs
//   rsp_valid/rsp_ready        response handshake
//   rsp_result, rsp_zero       captured ALU outputs
//   rsp_illegal                request was undecodable (result forced to 0)
//   op_count, illegal_count    saturating completion counters
module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_aluop,
   input  logic [5:0]       req_funct,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_cntrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_illegal,
   output logic [CNT_W-1:0] op_count,
   output logic [CNT_W-1:0] illegal_count
);

   seq_state_e       state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic [3:0]       cntrl_q;
   logic [WIDTH-1:0] rsp_result_q;
   logic             rsp_zero_q;
   logic             rsp_illegal_q;
   logic [CNT_W-1:0] op_cnt_q, ill_cnt_q;

   logic [3:0]       dec_cntrl;
   logic             dec_illegal;

   // Counters stick at all-ones rather than wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) return v;
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   alu_ctrl_decode u_decode (
      .aluop   (req_aluop),
      .funct   (req_funct),
      .cntrl   (dec_cntrl),
      .illegal (dec_illegal)
   );

   // Next state and handshake/ALU control outputs
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      alu_cntrl = CNTRL_ADD;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = dec_illegal ? RESP : EXEC;
         end
         EXEC: begin
            alu_cntrl = cntrl_q;
            state_d   = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, operand, response and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         a_q           <= '0;
         b_q           <= '0;
         cntrl_q       <= CNTRL_ADD;
         rsp_result_q  <= '0;
         rsp_zero_q    <= 1'b0;
         rsp_illegal_q <= 1'b0;
         op_cnt_q      <= '0;
         ill_cnt_q     <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  a_q     <= req_a;
                  b_q     <= req_b;
                  cntrl_q <= dec_cntrl;
                  // Illegal requests skip EXEC, so their response is built here
                  if (dec_illegal) begin
                     rsp_result_q  <= '0;
                     rsp_zero_q    <= 1'b0;
                     rsp_illegal_q <= 1'b1;
                  end
               end
            end
            EXEC: begin
               rsp_result_q  <= alu_result;
               rsp_zero_q    <= alu_zero;
               rsp_illegal_q <= 1'b0;
            end
            RESP: begin
               if (rsp_ready) begin
                  if (rsp_illegal_q) ill_cnt_q <= sat_inc(ill_cnt_q);
                  else               op_cnt_q  <= sat_inc(op_cnt_q);
               end
            end
            default: ;
         endcase
      end
   end

   assign alu_a         = a_q;
   assign alu_b         = b_q;
   assign rsp_result    = rsp_result_q;
   assign rsp_zero      = rsp_zero_q;
   assign rsp_illegal   = rsp_illegal_q;
   assign op_count      = op_cnt_q;
   assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer. Provides the combinational ALU,
// a transaction-level reference model checked every cycle, and directed
// requests with hand-computed expected values. Counters are built narrow so
// saturation is reachable in a short run.
module tb_alu_op_sequencer;

   localparam int WIDTH = 32;
   localparam int CNT_W = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [1:0]       req_aluop = 2'b00;
   logic [5:0]       req_funct = 6'b0;
   logic [WIDTH-1:0] req_a = '0, req_b = '0;
   logic [WIDTH-1:0] alu_a, alu_b;
   logic [3:0]       alu_cntrl;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_zero, rsp_illegal;
   logic [CNT_W-1:0] op_count, illegal_count;

   int checks = 0;
   int errors = 0;

   alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_aluop(req_aluop), .req_funct(req_funct),
      .req_a(req_a), .req_b(req_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
      .op_count(op_count), .illegal_count(illegal_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference semantics from the decode table
   function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                      output logic [3:0] code, output bit ill);
      code = 4'b0010;
      ill  = 0;
      if (op == 2'b00) code = 4'b0010;
      else if (op == 2'b01) code = 4'b0100;
      else if (op == 2'b11) ill = 1;
      else if (f == 6'b100000) code = 4'b0010;
      else if (f == 6'b100010) code = 4'b0100;
      else if (f == 6'b100100) code = 4'b0000;
      else if (f == 6'b100101) code = 4'b0001;
      else if (f == 6'b101010) code = 4'b1000;
      else ill = 1;
   endfunction

   function automatic logic [31:0] ref_alu(input logic [3:0] code, input logic [31:0] a,
                                           input logic [31:0] b);
      case (code)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0100: return a - b;
         4'b1000: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // The ALU the sequencer drives
   always_comb begin
      alu_result = ref_alu(alu_cntrl, alu_a, alu_b);
      alu_zero   = (alu_result == '0);
   end

   // Transaction model: one request in flight, response window and counters
   int          cyc = 0;
   bit          started = 0;
   bit          m_busy = 0;
   bit          m_ill = 0;
   int          m_from = 0, m_exec = 0;
   logic [3:0]  m_code;
   logic [31:0] m_a, m_b, m_res;
   bit          m_zero;
   int          m_op = 0, m_illc = 0;

   always @(posedge clk) begin
      cyc++;
      started = 1;
      if (rst) begin
         m_busy = 0;
         m_op   = 0;
         m_illc = 0;
      end else if (!m_busy) begin
         if (req_valid) begin
            ref_decode(req_aluop, req_funct, m_code, m_ill);
            m_a    = req_a;
            m_b    = req_b;
            m_res  = m_ill ? 32'd0 : ref_alu(m_code, req_a, req_b);
            m_zero = !m_ill && (m_res == 0);
            m_busy = 1;
            m_exec = cyc;
            m_from = m_ill ? cyc : cyc + 1;
         end
      end else if ((cyc - 1) >= m_from && rsp_ready) begin
         m_busy = 0;
         if (m_ill) begin
            if (m_illc < CNT_MAX) m_illc++;
         end else begin
            if (m_op < CNT_MAX) m_op++;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("req_ready", req_ready, !m_busy);
         chk("rsp_valid", rsp_valid, m_busy && cyc >= m_from);
         if (m_busy && cyc >= m_from) begin
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_zero", rsp_zero, m_zero);
            chk("rsp_illegal", rsp_illegal, m_ill);
         end
         chk("op_count", op_count, m_op);
         chk("illegal_count", illegal_count, m_illc);
         if (m_busy && !m_ill && cyc == m_exec) begin
            chk("exec_cntrl", alu_cntrl, m_code);
            chk("exec_alu_a", alu_a, m_a);
            chk("exec_alu_b", alu_b, m_b);
         end else begin
            chk("idle_cntrl", alu_cntrl, 4'b0010);
         end
      end
   end

   // Present a request and return at the falling edge after it is accepted
   task automatic send(input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      @(negedge clk);
      req_aluop = op; req_funct = f; req_a = a; req_b = b;
      req_valid = 1'b1;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", n, (n < 50) ? n : 0);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int exp_lat);
      int lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("rsp_latency", lat, exp_lat);
   endtask

   // Full transaction with literal expectations and optional backpressure
   task automatic run(input logic [1:0] op, input logic [5:0] f,
                      input logic [31:0] a, input logic [31:0] b, input int hold,
                      input logic [3:0] e_cntrl, input int e_lat,
                      input logic [31:0] e_res, input logic e_zero, input logic e_ill);
      send(op, f, a, b);
      chk("lit_cntrl", alu_cntrl, e_cntrl);
      wait_rsp(e_lat);
      chk("lit_result", rsp_result, e_res);
      chk("lit_zero", rsp_zero, e_zero);
      chk("lit_illegal", rsp_illegal, e_ill);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_result", rsp_result, e_res);
         chk("hold_ready", req_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      chk("rst_rsp_zero", rsp_zero, 1'b0);
      chk("rst_rsp_illegal", rsp_illegal, 1'b0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_cntrl", alu_cntrl, 4'b0010);
      chk("rst_op_count", op_count, 0);
      chk("rst_illegal_count", illegal_count, 0);
      rst = 1'b0;

      // Reset during EXEC discards the request
      send(2'b10, 6'b100000, 32'd5, 32'd7);
      chk("abort_exec_a", alu_a, 32'd5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_rsp_valid", rsp_valid, 1'b0);
      chk("abort_req_ready", req_ready, 1'b1);
      chk("abort_op_count", op_count, 0);
      chk("abort_alu_a", alu_a, 32'd0);
      repeat (2) @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 1'b0);

      run(2'b10, 6'b100000, 32'd5, 32'd7, 0, 4'b0010, 1, 32'd12, 1'b0, 1'b0);
      chk("op_count_1", op_count, 1);
      run(2'b01, 6'b000000, 32'h0000_00FF, 32'h0000_00FF, 0, 4'b0100, 1, 32'd0, 1'b1, 1'b0);
      run(2'b10, 6'b101010, 32'd3, 32'd9, 0, 4'b1000, 1, 32'd1, 1'b0, 1'b0);
      run(2'b10, 6'b101010, 32'd9, 32'd3, 0, 4'b1000, 1, 32'd0, 1'b1, 1'b0);
      run(2'b10, 6'b100111, 32'd1, 32'd2, 0, 4'b0010, 0, 32'd0, 1'b0, 1'b1);
      run(2'b11, 6'b100000, 32'd4, 32'd4, 2, 4'b0010, 0, 32'd0, 1'b0, 1'b1);
      chk("illegal_count_2", illegal_count, 2);
      chk("op_count_4", op_count, 4);

      // AND under backpressure with a second request waiting
      send(2'b10, 6'b100100, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      chk("and_cntrl", alu_cntrl, 4'b0000);
      wait_rsp(1);
      req_aluop = 2'b00; req_funct = 6'b0; req_a = 32'd100; req_b = 32'd200;
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("and_hold_result", rsp_result, 32'h00F0_00F0);
         chk("and_hold_valid", rsp_valid, 1'b1);
         chk("and_hold_ready", req_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("queued_ready", req_ready, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("queued_exec_a", alu_a, 32'd100);
      chk("queued_cntrl", alu_cntrl, 4'b0010);
      wait_rsp(1);
      chk("queued_result", rsp_result, 32'd300);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("op_count_6", op_count, 6);

      // Drive op_count past all-ones
      for (int i = 0; i < 11; i++)
         run(2'b00, 6'b0, i, 32'd1, 0, 4'b0010, 1, i + 1, 1'b0, 1'b0);
      chk("op_count_sat", op_count, CNT_MAX);
      chk("illegal_count_kept", illegal_count, 2);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
